sfif_stats: RTL and testbench

//  Parametrised event-statistics bank for the SFIF PCIe test path, on clk_125.

---
 rtl/sfif_stats_pkg.sv | 24 ++
 rtl/sfif_stats_if.sv | 13 +
 rtl/sfif_sat_cnt.sv | 28 ++
 rtl/sfif_stats.sv | 105 ++++++++++
 tb/tb_sfif_stats.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sfif_stats_pkg.sv
// Shared constants and helpers for the SFIF event-statistics bank.
package sfif_stats_pkg;

  // Read-address map: channel shadows occupy 0..NUM_CH-1, then these three words.
  function automatic int adr_elapsed(input int num_ch);
    return num_ch;
  endfunction

  function automatic int adr_ts(input int num_ch);
    return num_ch + 1;
  endfunction

  function automatic int adr_ovf(input int num_ch);
    return num_ch + 2;
  endfunction

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/sfif_stats_if.sv
// Host-side read port of the SFIF statistics bank.
interface sfif_stats_if #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 32
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;

  modport master (output rd_en, rd_addr, input rd_data, rd_valid);
  modport slave  (input rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/sfif_sat_cnt.sv
// Single event counter with synchronous clear and selectable saturate/wrap at all-ones.
module sfif_sat_cnt #(
  parameter int W   = 32,
  parameter bit SAT = 1'b1
) (
  input  logic         clk_125,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         ovf_pulse
);

  // An increment arriving at all-ones is the overflow event; clear takes priority.
  assign ovf_pulse = inc & ~clr & (&q);

  always_ff @(posedge clk_125) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      if (&q) q <= SAT ? q : '0;
      else    q <= q + W'(1);
    end
  end

endmodule

// File: rtl/sfif_stats.sv
// SFIF event-statistics bank: NUM_CH event counters plus elapsed and timestamp counters,
// snapshot shadows, sticky overflow flags, last-event timestamp capture and a registered read port.
module sfif_stats
  import sfif_stats_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter bit SAT    = 1'b1,
  parameter int TS_CH  = 0,
  parameter int ADDR_W = 3
) (
  input  logic              clk_125,
  input  logic              rstn,
  input  logic              run,
  input  logic              done,
  input  logic [NUM_CH-1:0] ev_i,
  input  logic              clr,
  input  logic              snap,
  output logic [NUM_CH-1:0] ovf,
  sfif_stats_if.slave       rd_bus
);

  localparam int ADR_EL  = adr_elapsed(NUM_CH);
  localparam int ADR_TS  = adr_ts(NUM_CH);
  localparam int ADR_OVF = adr_ovf(NUM_CH);
  localparam int NCNT    = NUM_CH + 2;
  localparam int TS_IDX  = NUM_CH + 1;

  if (NUM_CH < 1 || NUM_CH > CNT_W || TS_CH < 0 || TS_CH >= NUM_CH ||
      clog2(NUM_CH + 3) > ADDR_W) begin : g_param_err
    $error("sfif_stats: illegal NUM_CH/CNT_W/TS_CH/ADDR_W combination");
  end

  logic [NCNT-1:0][CNT_W-1:0] live;
  logic [NCNT-1:0]            inc;
  logic [NCNT-1:0]            ovf_pulse;
  logic [NUM_CH:0][CNT_W-1:0] sh_cnt;
  logic [CNT_W-1:0]           ts_cap;
  logic [CNT_W-1:0]           sh_ts;
  logic [NUM_CH-1:0]          sh_ovf;
  logic [CNT_W-1:0]           rd_tab [2**ADDR_W];

  // Counter order: channels, then elapsed (NUM_CH), then free-running timestamp (NUM_CH+1).
  assign inc = {run, run & ~done, ev_i};

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    sfif_sat_cnt #(.W(CNT_W), .SAT(SAT)) u_cnt (
      .clk_125   (clk_125),
      .rstn      (rstn),
      .clr       (clr),
      .inc       (inc[g]),
      .q         (live[g]),
      .ovf_pulse (ovf_pulse[g])
    );
  end

  wire unused_ovf_pulse = &{1'b0, ovf_pulse[NCNT-1:NUM_CH]};

  // Shadows sample pre-update values, so snap+clr in one cycle reads and clears atomically.
  always_ff @(posedge clk_125) begin
    if (!rstn) begin
      ovf    <= '0;
      ts_cap <= '0;
      sh_cnt <= '0;
      sh_ts  <= '0;
      sh_ovf <= '0;
    end else begin
      if (clr) begin
        ovf    <= '0;
        ts_cap <= '0;
      end else begin
        ovf <= ovf | ovf_pulse[NUM_CH-1:0];
        if (ev_i[TS_CH]) ts_cap <= live[TS_IDX];
      end
      if (snap) begin
        sh_cnt <= live[NUM_CH:0];
        sh_ts  <= ts_cap;
        sh_ovf <= ovf;
      end
    end
  end

  for (genvar a = 0; a < 2**ADDR_W; a++) begin : g_rd_tab
    if (a <= ADR_EL) begin : g_cnt_word
      assign rd_tab[a] = sh_cnt[a];
    end else if (a == ADR_TS) begin : g_ts_word
      assign rd_tab[a] = sh_ts;
    end else if (a == ADR_OVF) begin : g_ovf_word
      assign rd_tab[a] = CNT_W'(sh_ovf);
    end else begin : g_unmapped
      assign rd_tab[a] = '0;
    end
  end

  always_ff @(posedge clk_125) begin
    if (!rstn) begin
      rd_bus.rd_data  <= '0;
      rd_bus.rd_valid <= 1'b0;
    end else begin
      rd_bus.rd_valid <= rd_bus.rd_en;
      if (rd_bus.rd_en) rd_bus.rd_data <= rd_tab[rd_bus.rd_addr];
    end
  end

endmodule

// File: tb/tb_sfif_stats.sv
// Self-checking bench for sfif_stats: a saturating and a wrapping 8-bit instance driven in lockstep.
module tb_sfif_stats;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 3;
  localparam longint LIM = longint'(1) << CNT_W;

  logic clk_125 = 1'b0;
  always #4 clk_125 = ~clk_125;

  logic              rstn, run, done, clr, snap;
  logic [NUM_CH-1:0] ev_i;
  logic [NUM_CH-1:0] ovf_a, ovf_b;

  sfif_stats_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_a ();
  sfif_stats_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_b ();

  sfif_stats #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SAT(1'b1), .TS_CH(0), .ADDR_W(ADDR_W)) u_dut_a (
    .clk_125(clk_125), .rstn(rstn), .run(run), .done(done), .ev_i(ev_i),
    .clr(clr), .snap(snap), .ovf(ovf_a), .rd_bus(bus_a)
  );

  sfif_stats #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SAT(1'b0), .TS_CH(3), .ADDR_W(ADDR_W)) u_dut_b (
    .clk_125(clk_125), .rstn(rstn), .run(run), .done(done), .ev_i(ev_i),
    .clr(clr), .snap(snap), .ovf(ovf_b), .rd_bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: raw event totals since the last clear; visible values derived arithmetically.
  longint raw_ch [2][NUM_CH];
  longint raw_el [2];
  longint raw_ts [2];
  longint ts_cap [2];
  longint sh_ch  [2][NUM_CH];
  longint sh_el  [2];
  longint sh_ts  [2];
  longint sh_ovf [2];
  longint exp_rd [2];
  longint exp_valid [2];

  typedef struct {
    logic [NUM_CH-1:0] ev;
    logic              snap;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic              exp_valid;
    int                exp_data;
  } vec_t;

  vec_t tbl [14];

  function automatic bit inst_sat(input int i);
    return (i == 0);
  endfunction

  function automatic int inst_ts_ch(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic longint cnt_val(input longint raw, input bit sat);
    if (sat) return (raw >= LIM) ? LIM - 1 : raw;
    return raw % LIM;
  endfunction

  function automatic longint ovf_word(input int i);
    longint w = 0;
    for (int k = 0; k < NUM_CH; k++)
      if (raw_ch[i][k] >= LIM) w = w | (longint'(1) << k);
    return w;
  endfunction

  function automatic longint lookup(input int i, input int a);
    if (a < NUM_CH)     return sh_ch[i][a];
    if (a == NUM_CH)    return sh_el[i];
    if (a == NUM_CH + 1) return sh_ts[i];
    if (a == NUM_CH + 2) return sh_ovf[i];
    return 0;
  endfunction

  function automatic longint act_rd(input int i);
    return (i == 0) ? longint'(bus_a.rd_data) : longint'(bus_b.rd_data);
  endfunction

  function automatic longint act_valid(input int i);
    return (i == 0) ? longint'(bus_a.rd_valid) : longint'(bus_b.rd_valid);
  endfunction

  function automatic longint act_ovf(input int i);
    return (i == 0) ? longint'(ovf_a) : longint'(ovf_b);
  endfunction

  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        for (int k = 0; k < NUM_CH; k++) begin
          raw_ch[i][k] = 0;
          sh_ch[i][k]  = 0;
        end
        raw_el[i] = 0; raw_ts[i] = 0; ts_cap[i] = 0;
        sh_el[i] = 0; sh_ts[i] = 0; sh_ovf[i] = 0;
        exp_rd[i] = 0; exp_valid[i] = 0;
      end else begin
        exp_valid[i] = longint'(bus_a.rd_en);
        if (bus_a.rd_en) exp_rd[i] = lookup(i, int'(bus_a.rd_addr));
        if (snap) begin
          for (int k = 0; k < NUM_CH; k++) sh_ch[i][k] = cnt_val(raw_ch[i][k], inst_sat(i));
          sh_el[i]  = cnt_val(raw_el[i], inst_sat(i));
          sh_ts[i]  = ts_cap[i];
          sh_ovf[i] = ovf_word(i);
        end
        if (clr) begin
          for (int k = 0; k < NUM_CH; k++) raw_ch[i][k] = 0;
          raw_el[i] = 0; raw_ts[i] = 0; ts_cap[i] = 0;
        end else begin
          if (ev_i[inst_ts_ch(i)]) ts_cap[i] = cnt_val(raw_ts[i], inst_sat(i));
          for (int k = 0; k < NUM_CH; k++) if (ev_i[k]) raw_ch[i][k]++;
          if (run && !done) raw_el[i]++;
          if (run) raw_ts[i]++;
        end
      end
    end
  endtask

  task automatic checkVal(input string name, input int i, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d: got %0d expected %0d", name, i, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkVal({tag, ".rd_valid"}, i, act_valid(i), exp_valid[i]);
      checkVal({tag, ".rd_data"},  i, act_rd(i),    exp_rd[i]);
      checkVal({tag, ".ovf"},      i, act_ovf(i),   ovf_word(i));
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, then compare.
  task automatic applyStimulus(input string tag, input logic rstn_v, input logic run_v,
                               input logic done_v, input logic clr_v, input logic snap_v,
                               input logic [NUM_CH-1:0] ev_v, input logic rd_en_v,
                               input logic [ADDR_W-1:0] addr_v);
    rstn = rstn_v; run = run_v; done = done_v; clr = clr_v; snap = snap_v; ev_i = ev_v;
    bus_a.rd_en = rd_en_v; bus_a.rd_addr = addr_v;
    bus_b.rd_en = rd_en_v; bus_b.rd_addr = addr_v;
    @(posedge clk_125);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset(input logic run_v);
    applyStimulus("reset", 1'b0, run_v, 1'b0, 1'b0, 1'b0, '1, 1'b1, 3'd0);
    applyStimulus("reset", 1'b0, run_v, 1'b0, 1'b0, 1'b0, '1, 1'b1, 3'd1);
  endtask

  task automatic readBoth(input string tag, input logic [ADDR_W-1:0] addr, input longint exp_a,
                          input longint exp_b);
    applyStimulus(tag, 1'b1, run, done, 1'b0, 1'b0, '0, 1'b1, addr);
    checkVal({tag, ".const"}, 0, act_rd(0), exp_a);
    checkVal({tag, ".const"}, 1, act_rd(1), exp_b);
  endtask

  initial begin
    rstn = 1'b0; run = 1'b0; done = 1'b0; clr = 1'b0; snap = 1'b0; ev_i = '0;
    bus_a.rd_en = 1'b0; bus_a.rd_addr = '0;
    bus_b.rd_en = 1'b0; bus_b.rd_addr = '0;

    // Reset with all events high and a read pending: everything reads back zero.
    doReset(1'b1);
    for (int a = 0; a < 2**ADDR_W; a++) readBoth("t1.read", 3'(a), 0, 0);

    // Table-driven read-port vectors from a fresh reset with run=0.
    tbl = '{
      '{ev:4'b0011, snap:1'b0, rd_en:1'b0, addr:3'd0, exp_valid:1'b0, exp_data:0},
      '{ev:4'b0001, snap:1'b0, rd_en:1'b0, addr:3'd0, exp_valid:1'b0, exp_data:0},
      '{ev:4'b0100, snap:1'b0, rd_en:1'b0, addr:3'd0, exp_valid:1'b0, exp_data:0},
      '{ev:4'b0000, snap:1'b1, rd_en:1'b1, addr:3'd0, exp_valid:1'b1, exp_data:0},
      '{ev:4'b0000, snap:1'b0, rd_en:1'b1, addr:3'd0, exp_valid:1'b1, exp_data:2},
      '{ev:4'b0000, snap:1'b0, rd_en:1'b1, addr:3'd1, exp_valid:1'b1, exp_data:1},
      '{ev:4'b0000, snap:1'b0, rd_en:1'b1, addr:3'd2, exp_valid:1'b1, exp_data:1},
      '{ev:4'b0000, snap:1'b0, rd_en:1'b1, addr:3'd3, exp_valid:1'b1, exp_data:0},
      '{ev:4'b0000, snap:1'b0, rd_en:1'b1, addr:3'd4, exp_valid:1'b1, exp_data:0},
      '{ev:4'b0000, snap:1'b0, rd_en:1'b1, addr:3'd0, exp_valid:1'b1, exp_data:2},
      '{ev:4'b0000, snap:1'b0, rd_en:1'b0, addr:3'd5, exp_valid:1'b0, exp_data:2},
      '{ev:4'b0000, snap:1'b0, rd_en:1'b1, addr:3'd7, exp_valid:1'b1, exp_data:0},
      '{ev:4'b1111, snap:1'b0, rd_en:1'b1, addr:3'd6, exp_valid:1'b1, exp_data:0},
      '{ev:4'b0000, snap:1'b0, rd_en:1'b0, addr:3'd0, exp_valid:1'b0, exp_data:0}
    };
    doReset(1'b0);
    for (int v = 0; v < 14; v++) begin
      applyStimulus("tbl", 1'b1, 1'b0, 1'b0, 1'b0, tbl[v].snap, tbl[v].ev, tbl[v].rd_en, tbl[v].addr);
      for (int i = 0; i < 2; i++) begin
        checkVal($sformatf("tbl%0d.valid", v), i, act_valid(i), longint'(tbl[v].exp_valid));
        checkVal($sformatf("tbl%0d.data", v), i, act_rd(i), longint'(tbl[v].exp_data));
      end
    end

    // 37 events on channel 1.
    doReset(1'b0);
    for (int c = 0; c < 37; c++) applyStimulus("t2.count", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 3'd0);
    applyStimulus("t2.snap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0);
    readBoth("t2.read", 3'd1, 37, 37);

    // 260 events on channel 0: saturate vs wrap, both flag overflow.
    doReset(1'b0);
    for (int c = 0; c < 260; c++) applyStimulus("t3.count", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd0);
    applyStimulus("t3.snap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0);
    readBoth("t3.read", 3'd0, 255, 4);
    readBoth("t3.ovfword", 3'd6, 1, 1);
    checkVal("t3.ovf0", 0, longint'(ovf_a[0]), 1);
    checkVal("t3.ovf0", 1, longint'(ovf_b[0]), 1);

    // Read-and-clear with a coincident event on channel 2.
    doReset(1'b0);
    for (int c = 0; c < 10; c++) applyStimulus("t4.count", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 3'd0);
    applyStimulus("t4.snapclr", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 3'd0);
    readBoth("t4.shadow", 3'd2, 10, 10);
    applyStimulus("t4.snap2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0);
    readBoth("t4.live", 3'd2, 0, 0);

    // Timestamp capture with run from reset; done later freezes elapsed only.
    doReset(1'b1);
    for (int c = 0; c < 40; c++) begin
      applyStimulus("t5", 1'b1, 1'b1, (c >= 16), 1'b0, (c == 13 || c == 35),
                    (c == 5 || c == 12 || c == 30) ? 4'b1001 : 4'b0000,
                    (c == 14 || c == 15 || c == 36 || c == 37),
                    (c == 14 || c == 36) ? 3'd5 : 3'd4);
      if (c == 14) begin checkVal("t5.ts", 0, act_rd(0), 12); checkVal("t5.ts", 1, act_rd(1), 12); end
      if (c == 15) begin checkVal("t5.el", 0, act_rd(0), 13); checkVal("t5.el", 1, act_rd(1), 13); end
      if (c == 36) begin checkVal("t5.ts2", 0, act_rd(0), 30); checkVal("t5.ts2", 1, act_rd(1), 30); end
      if (c == 37) begin checkVal("t5.el2", 0, act_rd(0), 16); checkVal("t5.el2", 1, act_rd(1), 16); end
    end

    // Randomised traffic against the model.
    doReset(1'b0);
    for (int c = 0; c < 4000; c++) begin
      applyStimulus("rand", ($urandom_range(0, 499) != 0), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 699) == 0),
                    ($urandom_range(0, 7) == 0), 4'($urandom), 1'($urandom),
                    3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
